alu_input_loader: RTL

//  Front-end stage directly upstream of the ALU: captures operand A, operand B and the
//  6-bit operation code from board switches, one at a time, on presses of a load button.

---
 rtl/alu_input_loader_if.sv | 25 ++
 rtl/alu_input_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and registered operand outputs between the board front-end and the ALU.
// The master side drives switches and buttons; the slave side is the loader feeding the ALU.
interface alu_input_loader_if #(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
);
  logic [NBITS-1:0]  sw_data;
  logic              btn_load;
  logic              btn_clear;
  logic [NBITS-1:0]  operando_A;
  logic [NBITS-1:0]  operando_B;
  logic [COD_OP-1:0] cod_operacion;
  logic              operands_valid;
  logic [1:0]        state_o;

  modport master (
    output sw_data, btn_load, btn_clear,
    input  operando_A, operando_B, cod_operacion, operands_valid, state_o
  );

  modport slave (
    input  sw_data, btn_load, btn_clear,
    output operando_A, operando_B, cod_operacion, operands_valid, state_o
  );
endinterface

// File: rtl/alu_input_loader.sv
// Captures A, B and opcode from switches on debounced load presses; press -> update after DEBOUNCE_CYCLES+4 edges.
// No backpressure: the ALU consumes the registered operands continuously.
module alu_input_loader #(
  parameter int NBITS           = 8,
  parameter int COD_OP          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_input_loader_if.slave bus
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_READY = 2'b11
  } state_t;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [1:0]    pulse_q, pulse_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t            state_q, state_d;
  logic [NBITS-1:0]  a_q, a_d, b_q, b_d;
  logic [COD_OP-1:0] op_q, op_d;
  logic              valid_q, valid_d;

  assign raw = {bus.btn_clear, bus.btn_load};

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    pulse_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Clear takes priority over a simultaneous load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    if (pulse_q[1]) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (pulse_q[0]) begin
      case (state_q)
        S_A, S_READY: begin
          a_d     = bus.sw_data;
          state_d = S_B;
        end
        S_B: begin
          b_d     = bus.sw_data;
          state_d = S_OP;
        end
        default: begin
          op_d    = bus.sw_data[COD_OP-1:0];
          state_d = S_READY;
        end
      endcase
    end
    valid_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.operando_A     = a_q;
  assign bus.operando_B     = b_q;
  assign bus.cod_operacion  = op_q;
  assign bus.operands_valid = valid_q;
  assign bus.state_o        = state_q;
endmodule
